snake_input_ctrl: RTL and testbench
===================================

# snake_input_ctrl

Front-end stage for the seven-segment snake game: debounces and synchronises the four active-low direction buttons, queues the latest valid request, and emits a one-cycle game-step pulse with a direction code. It sits directly upstream of the game logic. It replaces that logic's free-running clock-divider bit and its raw button decode. The game advances exactly one cell per `tick` using `dir`.

## Interface

- `TICK_DIV`, default 67108864: clock cycles per game step (2^26 at 50 MHz, about 1.34 s); minimum 2.
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronised button level must stay stable before it is accepted (10 ms at 50 MHz); minimum 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `button_n`  in  4  raw active-low push buttons; bit k pressed requests direction code k.
- `pause`  in  1  level; high freezes the step counter and suppresses `tick`.
- `tick`  out  1  one-cycle game-step strobe.
- `dir`  out  2  current direction code, registered.
- `pend_valid`  out  1  a direction request is queued for the next tick.

## Operation

- Direction codes are 00, 01, 10 and 11.
  - The opposite of code c is c ^ 2'b10, so 00 and 10 are opposites, and 01 and 11 are opposites.
- **Synchroniser.** Each `button_n` bit passes through a 2-FF synchroniser.
- **Debouncer, per bit:**
  - It holds a stable level (reset value 1 = released) and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - While the synchronised input differs from the stable level, the counter increments. It resets to 0 whenever the input equals the stable level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the input still different, the stable level flips and the counter clears.
  - A 1->0 flip of the stable level produces a one-cycle `press[k]` event. Releases produce no event.
- **Request arbitration:**
  - If several `press` bits fire in the same cycle, the lowest index wins.
  - An event overwrites the pending register and sets `pend_valid`, so the last press before a tick wins.
- **Step counter:**
  - The counter has width clog2(TICK_DIV) and counts 0..TICK_DIV-1, then wraps to 0.
  - It holds its value while `pause`=1.
  - When it wraps with `pause`=0, `tick` is registered high for one cycle.
- **Direction update on the tick edge:**
  - At the same edge that sets `tick`, if `pend_valid`=1, the pending code p is examined.
  - If p != (`dir` ^ 2'b10), then `dir` <= p.
  - In either case `pend_valid` is cleared; a reversal request is discarded.
  - A request equal to `dir` is accepted with no visible change.
- **Reset.** While `rst`=1 at an edge:
  - `dir` = 2'b11, `tick` = 0, `pend_valid` = 0.
  - Step counter = 0.
  - All debouncer stable levels = 1 (released) and debouncer counters = 0.
  - Synchroniser flops = 1.
  - Reset mid-step or mid-debounce aborts everything; a button held through reset produces a `press` only after DEBOUNCE_CYCLES post-reset cycles.

## Timing

- **Button latency.** From a `button_n` falling edge to the `press` event: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles. `pend_valid` rises the cycle after the event.
- **Tick spacing.**
  - The first `tick` after reset occurs TICK_DIV cycles after reset deasserts.
  - Ticks are then spaced exactly TICK_DIV cycles apart while `pause`=0.
  - Pause cycles stretch the spacing 1:1.
- **Output alignment.**
  - `dir` and `tick` change on the same edge. Downstream logic samples `dir` in the `tick`-high cycle and sees the updated direction.
  - `dir` never changes outside a `tick` cycle.
- **Press and tick on the same edge.**
  - The `press` event is loaded into the pending register and `pend_valid` is set.
  - The old pending value is consumed by this tick.
  - The new request applies at the next tick.
- **Pause asserted at the wrap cycle.** `tick` is not generated; the counter holds at TICK_DIV-1 and wraps on the first unpaused cycle.
- **Latency rule.** A request accepted more than one cycle before a tick edge takes effect at that tick.

## Test plan

All scenarios use TICK_DIV=8 and DEBOUNCE_CYCLES=4.

1. **Reset and tick spacing.** Hold `rst` 3 cycles, release, leave buttons idle -> `dir`=11, `pend_valid`=0, `tick` pulses at cycles 8, 16, 24 after release, each exactly 1 cycle wide.
2. **Debounce and turn.**
   - Glitch `button_n[0]` low for 3 cycles, then high -> no `pend_valid`.
   - Hold `button_n[0]` low 10 cycles -> `pend_valid`=1 exactly 6 cycles after the falling edge.
   - At the next `tick`, `dir`=00 and `pend_valid`=0.
3. **Reversal rejection.** With `dir`=11, press button 1 -> at the next `tick` `dir` stays 11 and `pend_valid` clears. Then press button 0 -> `dir`=00.
4. **Last-wins and priority.**
   - Press button 2, then button 0 before the tick -> `dir`=00.
   - Release both, then press buttons 2 and 3 with identical timing -> pending code 10, applied if `dir`≠00.
5. **Pause.** Assert `pause` for 5 cycles starting at counter value 7 -> the tick is delayed by exactly 5 cycles, and `dir` is held meanwhile.
6. **Reset mid-operation.** With a pending request and the counter at 5, assert `rst` 1 cycle -> `pend_valid`=0, `dir`=11, and the next `tick` comes 8 cycles later. A button held throughout `rst` registers only after 4 + 2 cycles.

Source files
------------

// File: rtl/snake_input_ctrl.sv
// Snake game input front-end: button synchronise/debounce, request queueing,
// and a pausable step counter that strobes tick with the accepted direction.
module snake_input_ctrl #(
  parameter int unsigned TICK_DIV        = 67108864,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button_n,
  input  logic       pause,
  output logic       tick,
  output logic [1:0] dir,
  output logic       pend_valid
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NBTN   = 4;

  logic [NBTN-1:0]   sync1_q, sync2_q;
  logic [NBTN-1:0]   stable_q, stable_d;
  logic [DEB_W-1:0]  deb_cnt_q [NBTN];
  logic [DEB_W-1:0]  deb_cnt_d [NBTN];
  logic [NBTN-1:0]   press_c;
  logic [1:0]        req_code_c;
  logic [TICK_W-1:0] step_q, step_d;
  logic              tick_q, tick_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;

  // Debounce: flip the stable level once the input has differed for DEBOUNCE_CYCLES edges
  always_comb begin
    stable_d = stable_q;
    press_c  = '0;
    for (int k = 0; k < int'(NBTN); k++) begin
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (deb_cnt_q[k] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[k] = sync2_q[k];
          press_c[k]  = ~sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
        end
      end
    end
  end

  // Lowest-index press wins when several fire together
  always_comb begin
    req_code_c = 2'b00;
    for (int k = int'(NBTN) - 1; k >= 0; k--) begin
      if (press_c[k]) req_code_c = 2'(k);
    end
  end

  // Step counter, tick strobe, and direction/pending update
  always_comb begin
    step_d       = step_q;
    tick_d       = 1'b0;
    dir_d        = dir_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (!pause) begin
      if (step_q == TICK_W'(TICK_DIV - 1)) begin
        step_d = '0;
        tick_d = 1'b1;
      end else begin
        step_d = step_q + TICK_W'(1);
      end
    end
    if (tick_d) begin
      // A request that reverses the snake is dropped
      if (pend_valid_q && (pend_q != (dir_q ^ 2'b10))) dir_d = pend_q;
      pend_valid_d = 1'b0;
    end
    // A press landing on the tick edge is queued for the following tick
    if (|press_c) begin
      pend_d       = req_code_c;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      stable_q     <= '1;
      for (int k = 0; k < int'(NBTN); k++) deb_cnt_q[k] <= '0;
      step_q       <= '0;
      tick_q       <= 1'b0;
      dir_q        <= 2'b11;
      pend_q       <= 2'b00;
      pend_valid_q <= 1'b0;
    end else begin
      sync1_q      <= button_n;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      for (int k = 0; k < int'(NBTN); k++) deb_cnt_q[k] <= deb_cnt_d[k];
      step_q       <= step_d;
      tick_q       <= tick_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign tick       = tick_q;
  assign dir        = dir_q;
  assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed scenarios plus random button/pause/reset
// traffic, all checked each cycle against an event-level reference model.
module tb_snake_input_ctrl;

  localparam int TDIV = 8;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] button_n;
  logic       pause;
  logic       tick;
  logic [1:0] dir;
  logic       pend_valid;

  always #5 clk = ~clk;

  snake_input_ctrl #(.TICK_DIV(TDIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .button_n   (button_n),
    .pause      (pause),
    .tick       (tick),
    .dir        (dir),
    .pend_valid (pend_valid)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: raw button history, per-button streak of differing samples,
  // count of unpaused cycles since reset, and the game-facing outputs.
  logic [3:0] m_hist1, m_hist2, m_stable;
  int         m_streak [4];
  int         m_active;
  logic       m_tick;
  logic [1:0] m_dir, m_pend;
  logic       m_pv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] press;
    logic [1:0] code;
    if (rst) begin
      m_hist1 = 4'hF; m_hist2 = 4'hF; m_stable = 4'hF;
      for (int k = 0; k < 4; k++) m_streak[k] = 0;
      m_active = 0; m_tick = 1'b0; m_dir = 2'b11; m_pend = 2'b00; m_pv = 1'b0;
    end else begin
      press = '0;
      code  = 2'b00;
      for (int k = 0; k < 4; k++) begin
        if (m_hist2[k] != m_stable[k]) begin
          m_streak[k]++;
          if (m_streak[k] == DEB) begin
            m_stable[k] = m_hist2[k];
            m_streak[k] = 0;
            press[k]    = ~m_hist2[k];
          end
        end else begin
          m_streak[k] = 0;
        end
      end
      m_hist2 = m_hist1;
      m_hist1 = button_n;
      m_tick  = 1'b0;
      if (!pause) begin
        m_active++;
        m_tick = ((m_active % TDIV) == 0);
      end
      if (m_tick) begin
        if (m_pv && (m_pend != (m_dir ^ 2'b10))) m_dir = m_pend;
        m_pv = 1'b0;
      end
      for (int k = 3; k >= 0; k--) if (press[k]) code = 2'(k);
      if (|press) begin
        m_pend = code;
        m_pv   = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("tick", 32'(tick), 32'(m_tick));
    check("dir", 32'(dir), 32'(m_dir));
    check("pend_valid", 32'(pend_valid), 32'(m_pv));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Returns at the negedge following a tick edge (counter back at 0)
  task automatic wait_tick(input string tag);
    int k;
    k = 0;
    cycle();
    while (!tick && k < 40) begin
      cycle();
      k++;
    end
    check(tag, 32'(tick), 32'd1);
  endtask

  // Queue a request while the step counter is frozen, then let one tick apply it
  task automatic paused_press(input logic [3:0] mask, input string tag, input logic [1:0] exp_dir);
    pause    = 1'b1;
    button_n = mask;
    run(8);
    button_n = 4'hF;
    run(6);
    pause    = 1'b0;
    wait_tick({tag, "_tick"});
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
    check({tag, "_pv"}, 32'(pend_valid), 32'd0);
  endtask

  initial begin
    int ntick;
    int first;
    int hold;

    rst = 1'b1; pause = 1'b0; button_n = 4'hF;
    run(3);
    rst = 1'b0;

    // Idle after reset: ticks at cycles 8, 16, 24
    ntick = 0; first = -1;
    for (int c = 1; c <= 26; c++) begin
      cycle();
      if (tick) begin
        ntick++;
        if (first < 0) first = c;
      end
    end
    check("first_tick_cycle", 32'(first), 32'd8);
    check("tick_count", 32'(ntick), 32'd3);

    // 3-cycle glitch must be rejected
    button_n = 4'b1110;
    run(3);
    button_n = 4'hF;
    run(8);
    check("glitch_pv", 32'(pend_valid), 32'd0);

    // Held press: pend_valid exactly 6 cycles after the falling edge
    button_n = 4'b1110;
    run(5);
    check("deb_lat_early", 32'(pend_valid), 32'd0);
    run(1);
    check("deb_lat", 32'(pend_valid), 32'd1);
    run(4);
    button_n = 4'hF;
    wait_tick("turn_tick");
    check("turn_dir", 32'(dir), 32'd0);
    check("turn_pv", 32'(pend_valid), 32'd0);
    run(6);

    // Reversal (10 while heading 00) is discarded; 01 is accepted
    paused_press(4'b1011, "reverse", 2'b00);
    paused_press(4'b1101, "turn01", 2'b01);

    // Last press before the tick wins: 10 then 00
    pause    = 1'b1;
    button_n = 4'b1011;
    run(7);
    button_n = 4'b1110;
    run(7);
    button_n = 4'hF;
    run(6);
    pause    = 1'b0;
    wait_tick("lastwin_tick");
    check("lastwin_dir", 32'(dir), 32'd0);

    // Simultaneous buttons 2 and 3: code 10 wins (visible from heading 01)
    paused_press(4'b1101, "pre_prio", 2'b01);
    paused_press(4'b0011, "prio", 2'b10);

    // Pause for 5 cycles at counter 7 delays the tick by exactly 5
    wait_tick("align_tick");
    run(7);
    pause = 1'b1;
    run(5);
    pause = 1'b0;
    run(1);
    check("pause_tick", 32'(tick), 32'd1);

    // Reset with a request pending and the counter at 5; button held through it
    pause    = 1'b1;
    button_n = 4'b1101;
    run(6);
    check("pre_rst_pv", 32'(pend_valid), 32'd1);
    pause = 1'b0;
    run(5);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("rst_pv", 32'(pend_valid), 32'd0);
    check("rst_dir", 32'(dir), 32'd3);
    run(5);
    check("rst_btn_early", 32'(pend_valid), 32'd0);
    run(1);
    check("rst_btn_lat", 32'(pend_valid), 32'd1);
    run(1);
    check("rst_no_tick7", 32'(tick), 32'd0);
    run(1);
    check("rst_tick8", 32'(tick), 32'd1);
    button_n = 4'hF;
    run(8);

    // Random traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        for (int k = 0; k < 4; k++) button_n[k] = ($urandom_range(0, 2) != 0);
        hold = $urandom_range(1, 12);
      end
      pause = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      cycle();
      hold--;
    end
    rst = 1'b0;
    pause = 1'b0;
    button_n = 4'hF;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
